result_uart_framer: RTL and testbench

Downstream stage of the sparse systolic array. It accepts 2×8 INT32 result blocks, plus their block row/col tags, through a valid/ready handshake. Each block is serialised into a framed little-endian byte stream with a checksum, and the stream drives the UART TX byte interface. A 2-entry block buffer lets the array deliver the next result while the current frame is still streaming.

---
 rtl/sparse_pkg.sv | 19 +
 rtl/result_block_fifo.sv | 62 ++++++
 rtl/result_uart_framer.sv | 171 +++++++++++++++++
 tb/tb_result_uart_framer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse systolic array back end: framer states,
// sync marker default and the frame length helper.
package sparse_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CSUM
  } framerState_t;

  // Sync + row(2) + col(2) + payload + checksum
  function automatic int frameBytes(input int rows, input int cols, input int accWidth);
    return 5 + rows * cols * (accWidth / 8) + 1;
  endfunction

endpackage

// File: rtl/result_block_fifo.sv
// Two-entry buffer of result blocks with their row/col tags; the head entry
// stays visible until it is popped.
module result_block_fifo #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [15:0]       pushRow,
  input  logic [15:0]       pushCol,
  input  logic [DATA_W-1:0] pushData,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count,
  output logic [15:0]       headRow,
  output logic [15:0]       headCol,
  output logic [DATA_W-1:0] headData
);

  logic [15:0]       rowMem_q  [2];
  logic [15:0]       colMem_q  [2];
  logic [DATA_W-1:0] dataMem_q [2];
  logic              wrPtr_q, wrPtr_d;
  logic              rdPtr_q, rdPtr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    wrPtr_d = push ? ~wrPtr_q : wrPtr_q;
    rdPtr_d = pop  ? ~rdPtr_q : rdPtr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rowMem_q[wrPtr_q]  <= pushRow;
      colMem_q[wrPtr_q]  <= pushCol;
      dataMem_q[wrPtr_q] <= pushData;
    end
  end

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign headRow  = rowMem_q[rdPtr_q];
  assign headCol  = colMem_q[rdPtr_q];
  assign headData = dataMem_q[rdPtr_q];

endmodule

// File: rtl/result_uart_framer.sv
// Serialises buffered result blocks into sync/tag/payload/checksum frames
// on a byte-wide valid/ready stream toward the UART transmitter.
module result_uart_framer
  import sparse_pkg::*;
#(
  parameter int         PE_ROWS   = 2,
  parameter int         OUT_COLS  = 8,
  parameter int         ACC_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_enable,
  input  logic                                  res_valid,
  output logic                                  res_ready,
  input  logic [PE_ROWS*OUT_COLS*ACC_WIDTH-1:0] res_data,
  input  logic [15:0]                           res_block_row,
  input  logic [15:0]                           res_block_col,
  output logic                                  tx_valid,
  output logic [7:0]                            tx_data,
  output logic                                  tx_last,
  input  logic                                  tx_ready,
  output logic                                  busy,
  output logic [15:0]                           frames_sent
);

  localparam int         DATA_W    = PE_ROWS * OUT_COLS * ACC_WIDTH;
  localparam int         DBYTES    = DATA_W / 8;
  localparam int         IDXW      = $clog2(DBYTES);
  localparam int         BYTES     = frameBytes(PE_ROWS, OUT_COLS, ACC_WIDTH);
  localparam logic [6:0] LAST_HDR  = 7'd4;
  localparam logic [6:0] LAST_DATA = 7'(BYTES - 2);

  framerState_t      state_q, state_d;
  logic [6:0]        byteIdx_q, byteIdx_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        txData_q, txData_d;
  logic              txLast_q, txLast_d;
  logic [15:0]       framesSent_q, framesSent_d;

  logic              push, pop, accept, moreQueued;
  logic              fifoFull, fifoEmpty;
  logic [1:0]        fifoCount;
  logic [15:0]       headRow, headCol;
  logic [DATA_W-1:0] headData;
  logic [7:0]        dataBytes [DBYTES];
  logic [6:0]        nxtIdx, dataIdx;
  logic [7:0]        nextByte, csumNext;

  assign res_ready   = rst_n && cfg_enable && !fifoFull;
  assign push        = res_valid && res_ready;
  assign tx_valid    = (state_q != IDLE);
  assign accept      = tx_valid && tx_ready;
  assign pop         = accept && (state_q == CSUM);
  assign moreQueued  = (fifoCount == 2'd2) || push;
  assign busy        = !fifoEmpty || (state_q != IDLE);
  assign tx_data     = txData_q;
  assign tx_last     = txLast_q;
  assign frames_sent = framesSent_q;

  result_block_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .pushRow (res_block_row),
    .pushCol (res_block_col),
    .pushData(res_data),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount),
    .headRow (headRow),
    .headCol (headCol),
    .headData(headData)
  );

  // Payload is already little-endian element by element, so frame data byte k
  // is simply byte k of the packed block.
  for (genvar i = 0; i < DBYTES; i++) begin : g_bytes
    assign dataBytes[i] = headData[i*8 +: 8];
  end

  assign nxtIdx   = byteIdx_q + 7'd1;
  assign dataIdx  = nxtIdx - 7'd5;
  assign csumNext = csum_q ^ ((byteIdx_q == 7'd0) ? 8'h00 : txData_q);

  always_comb begin
    nextByte = 8'h00;
    case (nxtIdx)
      7'd1:    nextByte = headRow[7:0];
      7'd2:    nextByte = headRow[15:8];
      7'd3:    nextByte = headCol[7:0];
      7'd4:    nextByte = headCol[15:8];
      default: nextByte = dataBytes[dataIdx[IDXW-1:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byteIdx_q    <= 7'd0;
      csum_q       <= 8'h00;
      txData_q     <= 8'h00;
      txLast_q     <= 1'b0;
      framesSent_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      byteIdx_q    <= byteIdx_d;
      csum_q       <= csum_d;
      txData_q     <= txData_d;
      txLast_q     <= txLast_d;
      framesSent_q <= framesSent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifoEmpty) state_d = HDR;
      HDR:     if (accept && byteIdx_q == LAST_HDR) state_d = DATA;
      DATA:    if (accept && byteIdx_q == LAST_DATA) state_d = CSUM;
      CSUM:    if (accept) state_d = moreQueued ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered byte stream: the next byte is prepared on each handshake so
  // tx_data only changes when the current byte has been taken.
  always_comb begin
    byteIdx_d    = byteIdx_q;
    csum_d       = csum_q;
    txData_d     = txData_q;
    txLast_d     = txLast_q;
    framesSent_d = framesSent_q;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          byteIdx_d = 7'd0;
          csum_d    = 8'h00;
          txData_d  = SYNC_BYTE;
          txLast_d  = 1'b0;
        end
      end
      HDR, DATA: begin
        if (accept) begin
          byteIdx_d = nxtIdx;
          csum_d    = csumNext;
          if (state_q == DATA && byteIdx_q == LAST_DATA) begin
            txData_d = csumNext;
            txLast_d = 1'b1;
          end else begin
            txData_d = nextByte;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          framesSent_d = framesSent_q + 16'd1;
          txLast_d     = 1'b0;
          byteIdx_d    = 7'd0;
          csum_d       = 8'h00;
          txData_d     = moreQueued ? SYNC_BYTE : 8'h00;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_result_uart_framer.sv
// Scoreboard bench for result_uart_framer: expected frames are queued when a
// block is accepted and a monitor compares every byte the framer hands off.
module tb_result_uart_framer;

  localparam int NBYTES = 70;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_enable = 1'b1;
  logic         res_valid = 1'b0;
  logic         res_ready;
  logic [511:0] res_data = '0;
  logic [15:0]  res_block_row = '0;
  logic [15:0]  res_block_col = '0;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_last;
  logic         tx_ready = 1'b1;
  logic         busy;
  logic [15:0]  frames_sent;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } expByte_t;

  expByte_t   expQ[$];
  int         nChecks = 0;
  int         nFails = 0;
  int         cycleCnt = 0;
  int         readyMode = 0;
  int         pos = 0;
  int         lastCsumEdge = -1;
  int         acceptEdge = -1;
  logic [7:0] capBuf [NBYTES];
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;
  logic       gapPending = 1'b0;

  result_uart_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_enable   (cfg_enable),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_block_row(res_block_row),
    .res_block_col(res_block_col),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Downstream readiness: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference frame: sync, tags and payload little-endian, XOR over bytes 1..N-2
  task automatic pushModel(input logic [15:0] row, input logic [15:0] col, input logic [511:0] data);
    logic [7:0] fb [NBYTES];
    logic [7:0] cs;
    fb[0] = 8'hA5;
    fb[1] = row[7:0];
    fb[2] = row[15:8];
    fb[3] = col[7:0];
    fb[4] = col[15:8];
    for (int k = 0; k < 64; k++) fb[5 + k] = data[k*8 +: 8];
    cs = 8'h00;
    for (int k = 1; k < NBYTES - 1; k++) cs = cs ^ fb[k];
    fb[NBYTES-1] = cs;
    for (int k = 0; k < NBYTES; k++) expQ.push_back({fb[k], (k == NBYTES - 1)});
  endtask

  // Monitor: compares each handed-off byte and checks hold/no-gap behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall  = 1'b0;
      gapPending = 1'b0;
      pos        = 0;
    end else begin
      if (gapPending) begin
        checkOutput("no_gap_valid", 32'(tx_valid), 32'd1);
        checkOutput("no_gap_sync", 32'(tx_data), 32'hA5);
        gapPending = 1'b0;
      end
      if (prevStall) begin
        checkOutput("stall_valid_hold", 32'(tx_valid), 32'd1);
        checkOutput("stall_data_hold", 32'(tx_data), 32'(prevData));
        checkOutput("stall_last_hold", 32'(tx_last), 32'(prevLast));
      end
      if (tx_valid && tx_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          expByte_t e;
          e = expQ.pop_front();
          checkOutput("stream_byte", 32'(tx_data), 32'(e.b));
          checkOutput("stream_last", 32'(tx_last), 32'(e.last));
        end
        if (pos < NBYTES) capBuf[pos] = tx_data;
        pos++;
        if (tx_last) begin
          checkOutput("frame_length", 32'(pos), 32'(NBYTES));
          lastCsumEdge = cycleCnt + 1;
          pos = 0;
          if (expQ.size() > 0) gapPending = 1'b1;
        end
      end
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
      prevLast  = tx_last;
    end
  end

  task automatic applyStimulus(input logic [15:0] row, input logic [15:0] col, input logic [511:0] data);
    logic accepted;
    accepted      = 1'b0;
    res_block_row = row;
    res_block_col = col;
    res_data      = data;
    res_valid     = 1'b1;
    for (int i = 0; i < 600 && !accepted; i++) begin
      @(negedge clk);
      if (res_ready) begin
        accepted   = 1'b1;
        acceptEdge = cycleCnt + 1;
        pushModel(row, col, data);
      end
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input string name, input logic watchReady);
    logic done, readyLeak;
    done      = 1'b0;
    readyLeak = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (watchReady && res_ready) readyLeak = 1'b1;
      if (!busy && expQ.size() == 0) done = 1'b1;
    end
    checkOutput(name, 32'(done), 32'd1);
    if (watchReady) checkOutput("cfg_ready_low", 32'(readyLeak), 32'd0);
  endtask

  task automatic waitPos(input int target);
    logic reached;
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clk);
      if (pos >= target) reached = 1'b1;
    end
    checkOutput("wait_byte_position", 32'(reached), 32'd1);
  endtask

  task automatic doReset();
    res_valid = 1'b0;
    rst_n     = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("rst_res_ready", 32'(res_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_last", 32'(tx_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frames_sent", 32'(frames_sent), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_res_ready", 32'(res_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] d;

    doReset();

    // Single frame with one non-zero element
    readyMode = 0;
    d = '0;
    d[31:0] = 32'h1122_3344;
    applyStimulus(16'd3, 16'd5, d);
    @(negedge clk);
    checkOutput("latency_idle", 32'(tx_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_valid", 32'(tx_valid), 32'd1);
    checkOutput("latency_sync", 32'(tx_data), 32'hA5);
    waitIdle("single_drain", 1'b0);
    checkOutput("single_row_lo", 32'(capBuf[1]), 32'h03);
    checkOutput("single_col_lo", 32'(capBuf[3]), 32'h05);
    checkOutput("single_b5", 32'(capBuf[5]), 32'h44);
    checkOutput("single_b8", 32'(capBuf[8]), 32'h11);
    checkOutput("single_b9", 32'(capBuf[9]), 32'h00);
    checkOutput("single_csum", 32'(capBuf[69]), 32'h42);
    checkOutput("single_frames", 32'(frames_sent), 32'd1);
    checkOutput("single_busy", 32'(busy), 32'd0);

    // Reset in the middle of a frame abandons it
    d = '0;
    d[63:32] = 32'hCAFE_F00D;
    applyStimulus(16'h0102, 16'h0304, d);
    waitPos(30);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_frames", 32'(frames_sent), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d = '0;
    d[7:0] = 8'h5A;
    applyStimulus(16'd7, 16'd9, d);
    waitIdle("midrst_drain", 1'b0);
    checkOutput("midrst_fresh_sync", 32'(capBuf[0]), 32'hA5);
    checkOutput("midrst_frames_after", 32'(frames_sent), 32'd1);

    // Backpressure: two blocks buffered, third waits for the first pop
    doReset();
    readyMode = 1;
    @(posedge clk);
    #1;
    applyStimulus(16'd1, 16'd1, {16{32'h0101_0101}});
    applyStimulus(16'd2, 16'd2, {16{32'h0202_0202}});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_third_blocked", 32'(res_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    readyMode = 0;
    applyStimulus(16'd3, 16'd3, {16{32'h0303_0303}});
    checkOutput("bp_third_accept_edge", 32'(acceptEdge), 32'(lastCsumEdge + 1));
    waitIdle("bp_drain", 1'b0);
    checkOutput("bp_frames", 32'(frames_sent), 32'd3);

    // cfg_enable drops during frame 1 while frame 2 is buffered
    doReset();
    readyMode = 0;
    applyStimulus(16'h0010, 16'h0020, {16{32'h1234_5678}});
    applyStimulus(16'h0011, 16'h0021, {16{32'h9ABC_DEF0}});
    waitPos(10);
    cfg_enable = 1'b0;
    waitIdle("cfg_drain", 1'b1);
    checkOutput("cfg_frames", 32'(frames_sent), 32'd2);
    cfg_enable = 1'b1;

    // Random downstream stalls across three frames
    doReset();
    readyMode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      applyStimulus(16'($urandom), 16'($urandom), d);
    end
    waitIdle("rand_drain", 1'b0);
    checkOutput("rand_frames", 32'(frames_sent), 32'd3);
    readyMode = 0;

    // Last element of the block lands in the final four data bytes
    doReset();
    d = '0;
    d[15*32 +: 32] = 32'hDEAD_BEEF;
    applyStimulus(16'd1, 16'd2, d);
    waitIdle("boundary_drain", 1'b0);
    checkOutput("boundary_b65", 32'(capBuf[65]), 32'hEF);
    checkOutput("boundary_b66", 32'(capBuf[66]), 32'hBE);
    checkOutput("boundary_b67", 32'(capBuf[67]), 32'hAD);
    checkOutput("boundary_b68", 32'(capBuf[68]), 32'hDE);
    checkOutput("boundary_csum", 32'(capBuf[69]), 32'h21);
    checkOutput("boundary_frames", 32'(frames_sent), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
